// File: rtl/baud_generator.sv
// ============================================================================
// Module   : baud_generator
// Purpose  : SPI SCLK generator with programmable prescaler/divider, per-edge
//            shift/sample strobes and an end-of-frame pulse.
//            Optional macro BAUD_DIVISOR_PORT_EN exposes the latched divisor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module baud_generator (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       ss_i,
  input  logic [1:0] spi_mode_i,
  input  logic       spiswai_i,
  input  logic [2:0] sppr_i,
  input  logic [2:0] spr_i,
  input  logic       cpol_i,
  input  logic       cphase_i,
  output logic       sclk_o,
  output logic       mosi_send_sclk_o,
  output logic       miso_receive_sclk_o,
  output logic       mosi_send_sclk0_o,
  output logic       miso_receive_sclk0_o,
  output logic       done_o
`ifdef BAUD_DIVISOR_PORT_EN
  ,
  output logic [11:0] baud_rate_divisor_o
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [3:0]  edge_q, edge_d;
  logic [11:0] div_q, div_d;
  logic        sclk_q, sclk_d;
  logic        done_q, done_d;

  logic        enable;
  logic [11:0] div_calc;
  logic [11:0] half_m1;
  logic        at_half;
  logic        tick;

  // cphase only selects which strobe pair the shifter consumes downstream
  logic        unused_cphase;
  assign unused_cphase = cphase_i;

  assign enable   = !ss_i && (spi_mode_i == 2'b00 ||
                              (spi_mode_i == 2'b01 && !spiswai_i));
  assign div_calc = ({9'd0, sppr_i} + 12'd1) << ({1'b0, spr_i} + 4'd1);
  assign half_m1  = {1'b0, div_q[11:1]} - 12'd1;
  assign at_half  = (cnt_q == half_m1);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= 12'd0;
      edge_q  <= 4'd0;
      div_q   <= 12'd2;
      sclk_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      div_q   <= div_d;
      sclk_q  <= sclk_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    edge_d  = edge_q;
    div_d   = div_q;
    sclk_d  = sclk_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d  = 12'd0;
        edge_d = 4'd0;
        sclk_d = cpol_i;
        if (enable) begin
          state_d = ST_RUN;
          div_d   = div_calc;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_IDLE;
          cnt_d   = 12'd0;
          edge_d  = 4'd0;
          sclk_d  = cpol_i;
        end else if (at_half) begin
          cnt_d  = 12'd0;
          sclk_d = !sclk_q;
          edge_d = edge_q + 4'd1;
          // sixteenth toggle closes the 8-bit frame
          if (edge_q == 4'd15) begin
            state_d = ST_HALT;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      ST_HALT: begin
        cnt_d = 12'd0;
        if (ss_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    tick                 = !PRESET && (state_q == ST_RUN) && enable && at_half;
    mosi_send_sclk_o     = tick && sclk_q;
    miso_receive_sclk0_o = tick && sclk_q;
    miso_receive_sclk_o  = tick && !sclk_q;
    mosi_send_sclk0_o    = tick && !sclk_q;
  end

  assign sclk_o = sclk_q;
  assign done_o = done_q;
`ifdef BAUD_DIVISOR_PORT_EN
  assign baud_rate_divisor_o = div_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_baud_generator.sv
// ============================================================================
// Module   : tb_baud_generator
// Purpose  : Directed plus randomized checks of baud_generator against a
//            frame-level reference model (elapsed-cycle arithmetic).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_baud_generator;

  logic       PCLK;
  logic       PRESET;
  logic       ss_i;
  logic [1:0] spi_mode_i;
  logic       spiswai_i;
  logic [2:0] sppr_i;
  logic [2:0] spr_i;
  logic       cpol_i;
  logic       cphase_i;
  logic       sclk_o;
  logic       mosi_send_sclk_o;
  logic       miso_receive_sclk_o;
  logic       mosi_send_sclk0_o;
  logic       miso_receive_sclk0_o;
  logic       done_o;
`ifdef BAUD_DIVISOR_PORT_EN
  logic [11:0] baud_rate_divisor_o;
`endif

  baud_generator dut (
    .PCLK                 (PCLK),
    .PRESET               (PRESET),
    .ss_i                 (ss_i),
    .spi_mode_i           (spi_mode_i),
    .spiswai_i            (spiswai_i),
    .sppr_i               (sppr_i),
    .spr_i                (spr_i),
    .cpol_i               (cpol_i),
    .cphase_i             (cphase_i),
    .sclk_o               (sclk_o),
    .mosi_send_sclk_o     (mosi_send_sclk_o),
    .miso_receive_sclk_o  (miso_receive_sclk_o),
    .mosi_send_sclk0_o    (mosi_send_sclk0_o),
    .miso_receive_sclk0_o (miso_receive_sclk0_o),
    .done_o               (done_o)
`ifdef BAUD_DIVISOR_PORT_EN
    ,
    .baud_rate_divisor_o  (baud_rate_divisor_o)
`endif
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int errors = 0;
  int checks = 0;

  // Reference model: frame phase tracked as RUN cycles elapsed since start
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;
  int m_st;
  int m_t;
  int m_div;
  int m_h;
  bit m_start;
  bit m_sclk;
  bit m_done;

  int rise_cnt;
  int fall_cnt;
  int done_cnt;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int calc_div(input int pp, input int sr);
    return ((pp + 1) * (1 << (sr + 1))) & 'hFFF;
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_t = 0; m_div = 2; m_h = 1;
    m_start = 1'b0; m_sclk = 1'b0; m_done = 1'b0;
  endtask

  task automatic step();
    bit en;
    bit tick;
    @(negedge PCLK);
    en   = !ss_i && (spi_mode_i == 2'b00 || (spi_mode_i == 2'b01 && !spiswai_i));
    tick = !PRESET && m_st == M_RUN && en && ((m_t + 1) % m_h == 0);
    chk("sclk_o", {11'd0, sclk_o}, {11'd0, m_sclk});
    chk("mosi_send", {11'd0, mosi_send_sclk_o}, {11'd0, tick && m_sclk});
    chk("miso_recv0", {11'd0, miso_receive_sclk0_o}, {11'd0, tick && m_sclk});
    chk("miso_recv", {11'd0, miso_receive_sclk_o}, {11'd0, tick && !m_sclk});
    chk("mosi_send0", {11'd0, mosi_send_sclk0_o}, {11'd0, tick && !m_sclk});
    chk("done_o", {11'd0, done_o}, {11'd0, m_done});
`ifdef BAUD_DIVISOR_PORT_EN
    chk("divisor", baud_rate_divisor_o, 12'(m_div));
`endif
    rise_cnt += int'(miso_receive_sclk_o);
    fall_cnt += int'(mosi_send_sclk_o);
    done_cnt += int'(done_o);
    @(posedge PCLK);
    if (PRESET) begin
      model_reset();
    end else begin
      m_done = 1'b0;
      case (m_st)
        M_IDLE: begin
          m_sclk = cpol_i;
          if (en) begin
            m_st = M_RUN; m_t = 0; m_start = cpol_i;
            m_div = calc_div(int'(sppr_i), int'(spr_i));
            m_h = m_div / 2;
          end
        end
        M_RUN: begin
          if (!en) begin
            m_st = M_IDLE; m_sclk = cpol_i; m_t = 0;
          end else begin
            m_t++;
            m_sclk = m_start ^ bit'((m_t / m_h) % 2);
            if (m_t / m_h == 16) begin
              m_st = M_HALT; m_done = 1'b1;
            end
          end
        end
        default: begin
          if (ss_i) m_st = M_IDLE;
        end
      endcase
    end
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clr_counts();
    rise_cnt = 0; fall_cnt = 0; done_cnt = 0;
  endtask

  initial begin
    int hh;
    PRESET = 1'b1; ss_i = 1'b1; spi_mode_i = 2'b00; spiswai_i = 1'b0;
    sppr_i = 3'd0; spr_i = 3'd0; cpol_i = 1'b0; cphase_i = 1'b0;
    @(posedge PCLK); #1;
    model_reset();
    clr_counts();
    steps(3);
    PRESET = 1'b0;
    steps(2);

    // Fastest clock: toggle every PCLK
    clr_counts();
    ss_i = 1'b0;
    steps(24);
    chk("fast_rise_strobes", 12'(rise_cnt), 12'd8);
    chk("fast_fall_strobes", 12'(fall_cnt), 12'd8);
    chk("fast_done_pulses", 12'(done_cnt), 12'd1);

    // Divisor 12 with idle-high clock
    ss_i = 1'b1; steps(2);
    sppr_i = 3'd2; spr_i = 3'd1; cpol_i = 1'b1;
    clr_counts();
    ss_i = 1'b0;
    steps(16 * 6 + 6);
    chk("div12_rise_strobes", 12'(rise_cnt), 12'd8);
    chk("div12_done_pulses", 12'(done_cnt), 12'd1);

    // Mid-frame sppr change is ignored until next frame
    ss_i = 1'b1; steps(2);
    cpol_i = 1'b0;
    ss_i = 1'b0;
    steps(30);
    sppr_i = 3'd5;
    steps(80);
    ss_i = 1'b1; steps(2);
    clr_counts();
    ss_i = 1'b0;
    steps(16 * 12 + 4);
    chk("div24_done_pulses", 12'(done_cnt), 12'd1);

    // Abort after five toggles
    ss_i = 1'b1; steps(2);
    sppr_i = 3'd0; spr_i = 3'd1; cpol_i = 1'b1;
    clr_counts();
    ss_i = 1'b0;
    steps(11);
    ss_i = 1'b1;
    steps(6);
    chk("abort_done_pulses", 12'(done_cnt), 12'd0);

    // Wait mode with and without spiswai, stop mode, mid-frame reset
    spi_mode_i = 2'b01; spiswai_i = 1'b1; cpol_i = 1'b0;
    clr_counts();
    ss_i = 1'b0;
    steps(20);
    chk("wait_halted_strobes", 12'(rise_cnt + fall_cnt), 12'd0);
    spiswai_i = 1'b0;
    steps(16 * 2 + 4);
    chk("wait_run_done", 12'(done_cnt), 12'd1);
    ss_i = 1'b1; steps(2);
    spi_mode_i = 2'b10; ss_i = 1'b0;
    steps(6);
    spi_mode_i = 2'b00; cpol_i = 1'b1;
    steps(9);
    PRESET = 1'b1;
    steps(1);
    PRESET = 1'b0;
    steps(6);

    // Randomized frames, some aborted
    for (int f = 0; f < 8; f++) begin
      ss_i = 1'b1; steps(2);
      sppr_i = 3'($urandom_range(0, 3));
      spr_i  = 3'($urandom_range(0, 2));
      cpol_i = 1'($urandom);
      cphase_i = 1'($urandom);
      hh = calc_div(int'(sppr_i), int'(spr_i)) / 2;
      ss_i = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        steps(16 * hh + 4);
      end else begin
        steps($urandom_range(1, 16 * hh));
        ss_i = 1'b1;
        steps(3);
      end
    end

`ifdef BAUD_DIVISOR_PORT_EN
    // Max-setting boundary: largest prescaler and select
    ss_i = 1'b1; steps(2);
    sppr_i = 3'd7; spr_i = 3'd7;
    ss_i = 1'b0;
    steps(3);
    chk("max_setting_divisor", baud_rate_divisor_o, 12'(calc_div(7, 7)));
    ss_i = 1'b1; steps(2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
